// File: rtl/bayer_quad_demosaic_if.sv
// Stream bundle for the Bayer quad demosaic: raw Bayer samples in, RGB565 quads out.
// Handshake: bayer_dv and rgb_dv are one-cycle qualifiers with no ready/backpressure;
// a sample or pixel exists only on a cycle where its dv is high.
interface bayer_quad_demosaic_if #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
);
  localparam int AW = $clog2(IMG_W * IMG_H / 4);

  logic             VSYNC;
  logic [PIX_W-1:0] bayer_in;
  logic             bayer_dv;
  logic [15:0]      rgb;
  logic             rgb_dv;
  logic [AW-1:0]    rgb_addr;
  logic             frame_done;

  modport master (
    output VSYNC, bayer_in, bayer_dv,
    input  rgb, rgb_dv, rgb_addr, frame_done
  );

  modport slave (
    input  VSYNC, bayer_in, bayer_dv,
    output rgb, rgb_dv, rgb_addr, frame_done
  );
endinterface

// File: rtl/bayer_quad_demosaic.sv
// Streaming BGGR 2x2 quad to RGB565 converter: one output pixel per Bayer quad,
// tagged with its linear frame-buffer address.
module bayer_quad_demosaic #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input logic                  PCLK,
  input logic                  RST,
  bayer_quad_demosaic_if.slave bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int QW = $clog2(IMG_W / 2);
  localparam int AW = $clog2(IMG_W * IMG_H / 4);

  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [PIX_W-1:0]   hold;
  logic [2*PIX_W-1:0] rd_data;
  logic               synced;
  logic [15:0]        rgb_q;
  logic               rgb_dv_q;
  logic [AW-1:0]      rgb_addr_q;
  logic               frame_done_q;

  // One entry per quad column: {B, G1} from the even row, consumed on the odd row.
  logic [2*PIX_W-1:0] line_buf [0:IMG_W/2-1];

  logic          accept;
  logic          odd_row;
  logic          odd_col;
  logic          last_x;
  logic          last_y;
  logic [QW-1:0] qx;
  logic [4:0]    r5;
  logic [5:0]    g6;
  logic [4:0]    b5;

  assign accept  = synced && bus.bayer_dv && !bus.VSYNC;
  assign odd_row = y[0];
  assign odd_col = x[0];
  assign last_x  = (x == XW'(IMG_W - 1));
  assign last_y  = (y == YW'(IMG_H - 1));
  assign qx      = x[XW-1:1];

  // Green is the PIX_W+1 bit sum of both greens; all channels truncate to their MSBs.
  assign r5 = 5'(bus.bayer_in >> (PIX_W - 5));
  assign g6 = 6'(({1'b0, rd_data[PIX_W-1:0]} + {1'b0, hold}) >> (PIX_W - 5));
  assign b5 = 5'(rd_data[2*PIX_W-1:PIX_W] >> (PIX_W - 5));

  always_ff @(posedge PCLK) begin
    if (accept && !odd_row && odd_col) begin
      line_buf[qx] <= {hold, bus.bayer_in};
    end
  end

  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      synced       <= 1'b0;
      x            <= '0;
      y            <= '0;
      hold         <= '0;
      rd_data      <= '0;
      rgb_q        <= '0;
      rgb_dv_q     <= 1'b0;
      rgb_addr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rgb_dv_q     <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.VSYNC) begin
        synced <= 1'b1;
        x      <= '0;
        y      <= '0;
        hold   <= '0;
      end else if (accept) begin
        if (last_x) begin
          x <= '0;
          y <= last_y ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
        case ({odd_row, odd_col})
          2'b00: hold <= bus.bayer_in;
          2'b10: begin
            hold    <= bus.bayer_in;
            rd_data <= line_buf[qx];
          end
          2'b11: begin
            rgb_q        <= {r5, g6, b5};
            rgb_dv_q     <= 1'b1;
            rgb_addr_q   <= AW'((32'(y) >> 1) * 32'(IMG_W / 2) + 32'(qx));
            frame_done_q <= last_x && last_y;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rgb        = rgb_q;
  assign bus.rgb_dv     = rgb_dv_q;
  assign bus.rgb_addr   = rgb_addr_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_bayer_quad_demosaic.sv
// Bench for bayer_quad_demosaic: a raw-image model predicts every output cycle of an
// 8x4 instance, plus literal checks on a 4x2 instance and on logged strobe sequences.
module tb_bayer_quad_demosaic;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int PW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bayer_quad_demosaic_if #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) bus_b ();
  bayer_quad_demosaic_if #(.IMG_W(4), .IMG_H(2), .PIX_W(PW)) bus_a ();

  bayer_quad_demosaic #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut_b (
    .PCLK (clk),
    .RST  (rst),
    .bus  (bus_b)
  );

  bayer_quad_demosaic #(.IMG_W(4), .IMG_H(2), .PIX_W(PW)) dut_a (
    .PCLK (clk),
    .RST  (rst),
    .bus  (bus_a)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stores the raw image; when the R sample of a quad arrives, builds the pixel from
  // the four raw positions and queues {frame_done, addr, rgb} for the next cycle.
  logic [19:0] exp_q[$];
  bit          m_sync = 1'b0;
  int          mx = 0;
  int          my = 0;
  int          raw [H][W];
  int          qb, qg1, qg2, qr, qgs, qaddr;
  logic [15:0] qrgb;
  logic        qfd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sync = 1'b0;
      mx = 0;
      my = 0;
      exp_q.delete();
    end else if (bus_b.VSYNC) begin
      m_sync = 1'b1;
      mx = 0;
      my = 0;
    end else if (m_sync && bus_b.bayer_dv) begin
      raw[my][mx] = int'(bus_b.bayer_in);
      if ((my % 2 == 1) && (mx % 2 == 1)) begin
        qb    = raw[my-1][mx-1];
        qg1   = raw[my-1][mx];
        qg2   = raw[my][mx-1];
        qr    = raw[my][mx];
        qgs   = qg1 + qg2;
        qrgb  = 16'(((qr >> (PW - 5)) << 11) | (((qgs >> (PW - 5)) & 63) << 5) | (qb >> (PW - 5)));
        qaddr = (my / 2) * (W / 2) + (mx / 2);
        qfd   = (mx == W - 1) && (my == H - 1);
        exp_q.push_back({qfd, 3'(qaddr), qrgb});
      end
      mx++;
      if (mx == W) begin
        mx = 0;
        my++;
        if (my == H) my = 0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [15:0] h_rgb  = '0;
  logic [2:0]  h_addr = '0;
  logic [19:0] e;
  logic [15:0] log_rgb[$];
  logic [2:0]  log_addr[$];
  logic        log_fd[$];

  always @(negedge clk) begin
    if (rst) begin
      check("rst_rgb", bus_b.rgb, 0);
      check("rst_rgb_dv", bus_b.rgb_dv, 0);
      check("rst_addr", bus_b.rgb_addr, 0);
      check("rst_frame_done", bus_b.frame_done, 0);
      h_rgb  = '0;
      h_addr = '0;
    end else begin
      check("rgb_dv", bus_b.rgb_dv, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rgb", bus_b.rgb, e[15:0]);
        check("rgb_addr", bus_b.rgb_addr, e[18:16]);
        check("frame_done", bus_b.frame_done, e[19]);
        h_rgb  = e[15:0];
        h_addr = e[18:16];
      end else begin
        check("rgb_hold", bus_b.rgb, h_rgb);
        check("addr_hold", bus_b.rgb_addr, h_addr);
        check("frame_done_idle", bus_b.frame_done, 0);
      end
      if (bus_b.rgb_dv) begin
        log_rgb.push_back(bus_b.rgb);
        log_addr.push_back(bus_b.rgb_addr);
        log_fd.push_back(bus_b.frame_done);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Every drive call starts just after a rising edge and holds inputs for one clock.
  task automatic drive_b(input logic dv, input logic [PW-1:0] pix, input logic vs);
    bus_b.bayer_dv = dv;
    bus_b.bayer_in = pix;
    bus_b.VSYNC    = vs;
    @(posedge clk);
    #2;
    bus_b.bayer_dv = 1'b0;
    bus_b.VSYNC    = 1'b0;
  endtask

  task automatic drive_a(input logic dv, input logic [PW-1:0] pix, input logic vs);
    bus_a.bayer_dv = dv;
    bus_a.bayer_in = pix;
    bus_a.VSYNC    = vs;
    @(posedge clk);
    #2;
    bus_a.bayer_dv = 1'b0;
    bus_a.VSYNC    = 1'b0;
  endtask

  // mode 0: all FF; mode 1: pattern x*16+y*37+5. gap < 0 picks a random gap of 0..3.
  task automatic send_frame(input int mode, input int gap, input int n);
    int px, py, g;
    logic [PW-1:0] pix;
    for (int i = 0; i < n; i++) begin
      px  = i % W;
      py  = (i / W) % H;
      pix = (mode == 0) ? 8'hFF : 8'((px * 16 + py * 37 + 5) & 255);
      drive_b(1'b1, pix, 1'b0);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) drive_b(1'b0, '0, 1'b0);
    end
  endtask

  task automatic vsync_b();
    drive_b(1'b0, '0, 1'b1);
  endtask

  task automatic flush_b();
    repeat (3) drive_b(1'b0, '0, 1'b0);
  endtask

  task automatic clear_log();
    log_rgb.delete();
    log_addr.delete();
    log_fd.delete();
  endtask

  task automatic check_ff_frame(input string name);
    check({name, "_count"}, log_rgb.size(), 8);
    if (log_rgb.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check({name, "_rgb"}, log_rgb[i], 16'hFFFF);
        check({name, "_addr"}, log_addr[i], i);
        check({name, "_fd"}, log_fd[i], (i == 7));
      end
    end
  endtask

  function automatic int fd_count();
    int c = 0;
    foreach (log_fd[i]) c += int'(log_fd[i]);
    return c;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus_b.bayer_dv = 1'b0;
    bus_b.bayer_in = '0;
    bus_b.VSYNC    = 1'b0;
    bus_a.bayer_dv = 1'b0;
    bus_a.bayer_in = '0;
    bus_a.VSYNC    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // T1: 4x2 frame, both quads B=10 G1=20 G2=40 R=80 -> 8182
    drive_a(1'b0, '0, 1'b1);
    drive_a(1'b1, 8'h10, 1'b0);
    drive_a(1'b1, 8'h20, 1'b0);
    drive_a(1'b1, 8'h10, 1'b0);
    drive_a(1'b1, 8'h20, 1'b0);
    drive_a(1'b1, 8'h40, 1'b0);
    drive_a(1'b1, 8'h80, 1'b0);
    #1;
    check("t1_dv0", bus_a.rgb_dv, 1);
    check("t1_rgb0", bus_a.rgb, 16'h8182);
    check("t1_addr0", bus_a.rgb_addr, 0);
    check("t1_fd0", bus_a.frame_done, 0);
    drive_a(1'b1, 8'h40, 1'b0);
    #1;
    check("t1_gap_dv", bus_a.rgb_dv, 0);
    drive_a(1'b1, 8'h80, 1'b0);
    #1;
    check("t1_dv1", bus_a.rgb_dv, 1);
    check("t1_addr1", bus_a.rgb_addr, 1);
    check("t1_fd1", bus_a.frame_done, 1);
    drive_a(1'b0, '0, 1'b0);
    #1;
    check("t1_after_dv", bus_a.rgb_dv, 0);
    check("t1_after_fd", bus_a.frame_done, 0);
    check("t1_rgb_held", bus_a.rgb, 16'h8182);

    // T2: full FF frame back-to-back
    clear_log();
    vsync_b();
    send_frame(0, 0, W * H);
    flush_b();
    check_ff_frame("t2");

    // T3: same frame, one sample every 3rd cycle
    clear_log();
    vsync_b();
    send_frame(0, 2, W * H);
    flush_b();
    check_ff_frame("t3");

    // T4: VSYNC after 5 samples abandons the partial frame
    clear_log();
    vsync_b();
    send_frame(1, 0, 5);
    vsync_b();
    send_frame(1, 0, W * H);
    flush_b();
    check("t4_count", log_rgb.size(), 8);
    check("t4_first_addr", (log_addr.size() > 0) ? 32'(log_addr[0]) : 32'hDEAD, 0);
    check("t4_first_rgb", (log_rgb.size() > 0) ? 32'(log_rgb[0]) : 32'hDEAD, 16'h38E0);
    check("t4_fd_count", fd_count(), 1);

    // T5: reset mid-frame, then samples with no VSYNC are ignored
    clear_log();
    vsync_b();
    send_frame(1, 0, 10);
    rst = 1'b1;
    drive_b(1'b0, '0, 1'b0);
    drive_b(1'b0, '0, 1'b0);
    rst = 1'b0;
    clear_log();
    send_frame(1, 0, W * H);
    flush_b();
    check("t5_no_output", log_rgb.size(), 0);
    clear_log();
    vsync_b();
    send_frame(0, 0, W * H);
    flush_b();
    check_ff_frame("t5");

    // T6: two frames back-to-back without VSYNC, random gaps
    clear_log();
    vsync_b();
    send_frame(1, -1, W * H);
    send_frame(0, -1, W * H);
    flush_b();
    check("t6_count", log_rgb.size(), 16);
    check("t6_fd_count", fd_count(), 2);
    if (log_rgb.size() == 16) begin
      check("t6_addr_restart", log_addr[8], 0);
      check("t6_fd_first", log_fd[7], 1);
      check("t6_fd_second", log_fd[15], 1);
      check("t6_rgb_second", log_rgb[8], 16'hFFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
